adder_seq_ctrl: RTL and testbench

Multi-cycle 18-bit add/subtract sequencer that reuses one 2-bit full-adder slice instead of a full 18-bit ripple chain. It processes the operands 2 bits per cycle, least-significant slice first, and keeps the inter-slice carry in a register. It sits in the datapath next to the ALU as the area-reduced arithmetic unit and connects to the control unit through a start/busy/done handshake. It produces sum, carry-out, zero and signed-overflow flags.

---
 rtl/adder_seq_pkg.sv | 19 +
 rtl/adder_seq_ctrl_if.sv | 27 ++
 rtl/add2_slice.sv | 19 +
 rtl/adder_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_adder_seq_ctrl.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/adder_seq_pkg.sv
// Shared constants and types for the slice-serial add/subtract sequencer.
// WIDTH must be a multiple of SLICE; STEPS is derived from the two.
package adder_seq_pkg;

  localparam int unsigned WIDTH = 18;
  localparam int unsigned SLICE = 2;
  localparam int unsigned STEPS = WIDTH / SLICE;
  localparam int unsigned IDX_W = $clog2(STEPS);

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/adder_seq_ctrl_if.sv
// Start/busy/done handshake and operand/result bundle between the control unit
// and the sequencer.
interface adder_seq_ctrl_if;
  import adder_seq_pkg::*;

  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             zero;
  logic             ovf;

  modport master (
    output start, op, a, b,
    input  busy, done, result, c_out, zero, ovf
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, c_out, zero, ovf
  );

endinterface

// File: rtl/add2_slice.sv
// Combinational 2-bit full adder made from two chained 1-bit full adders.
module add2_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       c_in,
  output logic [1:0] s,
  output logic       c_out
);

  logic c_mid;

  always_comb begin
    s[0]  = a[0] ^ b[0] ^ c_in;
    c_mid = (a[0] & b[0]) | (a[0] & c_in) | (b[0] & c_in);
    s[1]  = a[1] ^ b[1] ^ c_mid;
    c_out = (a[1] & b[1]) | (a[1] & c_mid) | (b[1] & c_mid);
  end

endmodule

// File: rtl/adder_seq_ctrl.sv
// Slice-serial add/subtract: one add2_slice consumes the operands SLICE bits per
// cycle, LSB first, with the inter-slice carry held in a register.
module adder_seq_ctrl
  import adder_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  adder_seq_ctrl_if.slave   bus
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(STEPS - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, acc_fin;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             op_q, op_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             c_out_q, c_out_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [1:0]       slice_s;
  logic             slice_c;

  add2_slice u_slice (
    .a     (a_sh_q[SLICE-1:0]),
    .b     (b_sh_q[SLICE-1:0]),
    .c_in  (carry_q),
    .s     (slice_s),
    .c_out (slice_c)
  );

  // Accumulator with the current slice merged in; on the last step this is the final sum.
  always_comb begin
    acc_fin = acc_q;
    acc_fin[SLICE*idx_q +: SLICE] = slice_s;
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    op_d     = op_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    result_d = result_q;
    c_out_d  = c_out_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = (bus.op == OP_SUB) ? ~bus.b : bus.b;
          carry_d = bus.op;
          op_d    = bus.op;
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = bus.b[WIDTH-1];
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d   = acc_fin;
        carry_d = slice_c;
        a_sh_d  = a_sh_q >> SLICE;
        b_sh_d  = b_sh_q >> SLICE;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LastIdx) begin
          state_d  = StDone;
          result_d = acc_fin;
          c_out_d  = slice_c;
          zero_d   = (acc_fin == '0);
          // Operand B's MSB as seen by the adder is inverted for subtract.
          ovf_d    = (a_msb_q == (b_msb_q ^ op_q)) && (acc_fin[WIDTH-1] != a_msb_q);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d == StRun);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      op_q     <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.c_out  = c_out_q;
  assign bus.zero   = zero_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench: the driver queues hand-computed results, a negedge monitor
// checks every done pulse against the queue, including latency and busy length.
module tb_adder_seq_ctrl;
  import adder_seq_pkg::*;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             c;
    logic             z;
    logic             v;
    int unsigned      due;
  } exp_t;

  logic        clk;
  logic        rst;
  int unsigned cyc;
  int unsigned n_tests;
  int unsigned n_fail;
  int unsigned run_busy;
  exp_t        sb[$];

  adder_seq_ctrl_if bus ();

  adder_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.busy) run_busy++;
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("result", 32'(bus.result), 32'(e.res));
          chk("c_out", 32'(bus.c_out), 32'(e.c));
          chk("zero", 32'(bus.zero), 32'(e.z));
          chk("ovf", 32'(bus.ovf), 32'(e.v));
          chk("done_cycle", cyc, e.due);
          chk("busy_cycles", run_busy, 32'd9);
        end
        run_busy = 0;
      end
    end
  end

  task automatic push(input logic [WIDTH-1:0] res, input logic c, input logic z, input logic v);
    exp_t e;
    e.res = res;
    e.c   = c;
    e.z   = z;
    e.v   = v;
    e.due = cyc + 10;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] res, input logic c, input logic z,
                       input logic v);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    push(res, c, z, v);
    @(negedge clk);
    bus.start = 1'b0;
    drain();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_result"}, 32'(bus.result), 32'd0);
    chk({tag, "_c_out"}, 32'(bus.c_out), 32'd0);
    chk({tag, "_zero"}, 32'(bus.zero), 32'd0);
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
    chk({tag, "_state"}, 32'(dut.state_q), 32'(StIdle));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 300000");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc       = 0;
    n_tests   = 0;
    n_fail    = 0;
    run_busy  = 0;
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.op    = OP_ADD;
    bus.a     = 18'h00003;
    bus.b     = 18'h00004;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    bus.start = 1'b0;
    rst       = 1'b0;
    @(negedge clk);

    issue(OP_ADD, 18'h00001, 18'h00001, 18'h00002, 1'b0, 1'b0, 1'b0);
    issue(OP_ADD, 18'h3FFFF, 18'h00001, 18'h00000, 1'b1, 1'b1, 1'b0);
    issue(OP_SUB, 18'h00005, 18'h00007, 18'h3FFFE, 1'b0, 1'b0, 1'b0);
    issue(OP_ADD, 18'h1FFFF, 18'h00001, 18'h20000, 1'b0, 1'b0, 1'b1);
    issue(OP_SUB, 18'h20000, 18'h00001, 18'h1FFFF, 1'b1, 1'b0, 1'b1);

    // Abort in the 4th RUN cycle; outputs still hold the previous nonzero result.
    bus.start = 1'b1;
    bus.op    = OP_ADD;
    bus.a     = 18'h3FFFF;
    bus.b     = 18'h3FFFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_abort_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("abort");
    rst      = 1'b0;
    run_busy = 0;
    issue(OP_ADD, 18'h00003, 18'h00004, 18'h00007, 1'b0, 1'b0, 1'b0);

    // start held through RUN and the DONE cycle with junk operands, then a real request.
    bus.start = 1'b1;
    bus.op    = OP_ADD;
    bus.a     = 18'h12345;
    bus.b     = 18'h0ABCD;
    push(18'h1CF12, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.op = OP_SUB;
      bus.a  = 18'h3FFFF;
      bus.b  = 18'h15555;
    end
    chk("done_cycle_start_seen", 32'(bus.done), 32'd1);
    @(negedge clk);
    bus.op = OP_SUB;
    bus.a  = 18'h00100;
    bus.b  = 18'h00100;
    push(18'h00000, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    drain();
    repeat (15) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
